pipe_hazard_ctrl: RTL and testbench

- Central hazard controller for the 5-stage pipelined RISC-V core (F/D/E/M/W).
- Generates per-stage stall and flush controls, plus E-stage operand forwarding selects.
- Freezes the pipeline while the data memory is not ready, with a bounded-wait watchdog.
- Drives the enable/clear inputs of every pipeline register, including the M→W register that carries RegWrite/ResultSrc.

---
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage RISC-V pipeline: stall/flush generation, E-stage forwarding,
// and a memory-wait FSM whose watchdog freezes the pipeline permanently on a stuck data memory.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemAccessM,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_busy,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [7:0]       LAST_WAIT = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t     state, stateNext;
    logic [7:0] waitCnt, waitCntNext;
    logic       notReady, memStall, lwStall;

    // M-stage result is younger than W, so it wins when both target the same register.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
    end

    assign notReady = MemAccessM & ~dmem_ready;
    assign memStall = notReady | (state == ERR);
    assign lwStall  = (ResultSrcE == 2'b01) && (RdE != 5'd0)
                      && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;

    // A frozen pipeline must not flush: a taken branch waits in E until the memory releases.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (memStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lwStall;
            StallD = lwStall;
            FlushD = PCSrcE;
            FlushE = lwStall | PCSrcE;
        end
    end

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        case (state)
            RUN: begin
                if (notReady) begin
                    stateNext   = WAIT;
                    waitCntNext = 8'd1;
                end
            end
            WAIT: begin
                if (!notReady) begin
                    stateNext   = RUN;
                    waitCntNext = 8'd0;
                end else if (waitCnt == LAST_WAIT) begin
                    stateNext = ERR;
                end else begin
                    waitCntNext = waitCnt + 8'd1;
                end
            end
            ERR: begin
                stateNext = ERR;
            end
            default: begin
                stateNext   = RUN;
                waitCntNext = 8'd0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            waitCnt <= 8'd0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (StallF && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end

    assign mem_busy = (state == WAIT);
    assign mem_err  = (state == ERR);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each cycle's expected outputs are queued when the
// stimulus is applied and compared at the following falling edge.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, RegWriteW, PCSrcE, MemAccessM, dmem_ready;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       mem_busy, mem_err;
    logic [3:0] stall_count;

    int         nChecks = 0;
    int         nBad    = 0;
    logic [3:0] expCount = 4'd0;
    string      tagQ[$];
    logic [16:0] expQ[$];

    // Output vector layout: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,FwdA,FwdB,busy,err,count}
    localparam logic [6:0] C_NONE = 7'b0000_000;
    localparam logic [6:0] C_LW   = 7'b1100_010;
    localparam logic [6:0] C_MEM  = 7'b1111_001;
    localparam logic [6:0] C_BR   = 7'b0000_110;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemAccessM(MemAccessM), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_busy(mem_busy), .mem_err(mem_err), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] actual();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                ForwardAE, ForwardBE, mem_busy, mem_err, stall_count};
    endfunction

    function automatic void push(string tag, logic [6:0] ctl, logic [1:0] fa, logic [1:0] fb,
                                 logic busy, logic err);
        tagQ.push_back(tag);
        expQ.push_back({ctl, fa, fb, busy, err, expCount});
    endfunction

    // Pop one expectation, compare at the falling edge, then advance the reference counter.
    task automatic tick();
        logic [16:0] act, exp;
        string tag;
        @(negedge clk);
        act = actual();
        nChecks++;
        if (expQ.size() == 0) begin
            nBad++;
            $display("FAIL sb_empty: got %b with no expectation queued", act);
        end else begin
            exp = expQ.pop_front();
            tag = tagQ.pop_front();
            if (act !== exp) begin
                nBad++;
                $display("FAIL %s: got %b required %b", tag, act, exp);
            end
            if (exp[16] && expCount != 4'hF) expCount = expCount + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00;
        RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
        MemAccessM = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        #2;
        nChecks++;
        if (actual() !== 17'd0) begin
            nBad++;
            $display("FAIL reset_outputs: got %b required %b", actual(), 17'd0);
        end
        #1 reset = 1'b0;
        expCount = 4'd0;
        @(posedge clk);
        #1;
        push("idle_after_reset", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_forwarding();
        RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd6;
        push("fwd_m_priority", C_NONE, 2'b10, 2'b00, 1'b0, 1'b0); tick();
        RegWriteM = 1'b0;
        push("fwd_w_only", C_NONE, 2'b01, 2'b00, 1'b0, 1'b0); tick();
        RdM = 5'd0; RdW = 5'd0;
        push("fwd_none", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        RegWriteM = 1'b1; RdM = 5'd6; RegWriteW = 1'b1; RdW = 5'd5;
        push("fwd_split_ab", C_NONE, 2'b01, 2'b10, 1'b0, 1'b0); tick();
        RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        push("fwd_x0_never", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        clear_inputs();
    endtask

    task automatic test_load_use();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        push("lw_rs2", C_LW, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        ResultSrcE = 2'b00;
        push("lw_gone", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        ResultSrcE = 2'b01; RdE = 5'd0; Rs2D = 5'd0;
        push("lw_x0", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        RdE = 5'd9; Rs1D = 5'd9;
        push("lw_rs1", C_LW, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        PCSrcE = 1'b1;
        push("lw_with_branch", C_BR, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        ResultSrcE = 2'b10;
        push("pc4_no_stall", C_BR, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        MemAccessM = 1'b1; dmem_ready = 1'b0;
        push("mw_c1", C_MEM, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        push("mw_c2", C_MEM, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        push("mw_c3", C_MEM, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        dmem_ready = 1'b1;
        push("mw_release", C_NONE, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        clear_inputs();
        push("mw_idle", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        // Access withdrawn mid-wait also returns the FSM to RUN.
        MemAccessM = 1'b1;
        push("mw_drop_c1", C_MEM, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        MemAccessM = 1'b0;
        push("mw_drop_c2", C_NONE, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        push("mw_drop_idle", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0); tick();
    endtask

    task automatic test_deferred_flush();
        PCSrcE = 1'b1; MemAccessM = 1'b1; dmem_ready = 1'b0;
        ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
        push("df_c1", C_MEM, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        push("df_c2", C_MEM, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        dmem_ready = 1'b1;
        push("df_release", C_BR, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        clear_inputs();
        push("df_idle", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0); tick();
    endtask

    task automatic test_watchdog();
        MemAccessM = 1'b1; dmem_ready = 1'b0;
        push("wd_c1", C_MEM, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        for (int i = 2; i <= 4; i++) begin
            push($sformatf("wd_c%0d", i), C_MEM, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        end
        push("wd_err", C_MEM, 2'b00, 2'b00, 1'b0, 1'b1); tick();
        dmem_ready = 1'b1; MemAccessM = 1'b0; PCSrcE = 1'b1;
        push("wd_err_hold1", C_MEM, 2'b00, 2'b00, 1'b0, 1'b1); tick();
        push("wd_err_hold2", C_MEM, 2'b00, 2'b00, 1'b0, 1'b1); tick();
        #1 reset = 1'b1;
        clear_inputs();
        #1;
        nChecks++;
        if ({mem_err, mem_busy, stall_count, StallF} !== 7'd0) begin
            nBad++;
            $display("FAIL wd_reset: got err=%b busy=%b cnt=%0d stallF=%b required all 0",
                     mem_err, mem_busy, stall_count, StallF);
        end
        #1 reset = 1'b0;
        expCount = 4'd0;
        MemAccessM = 1'b1;
        push("wd_after_reset", C_MEM, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        dmem_ready = 1'b1;
        push("wd_after_release", C_NONE, 2'b00, 2'b00, 1'b1, 1'b0); tick();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        // Continuous load-use stalls drive the 4-bit counter into saturation.
        ResultSrcE = 2'b01; RdE = 5'd12; Rs2D = 5'd12;
        for (int i = 0; i < 18; i++) begin
            push($sformatf("b2b_lw%0d", i), C_LW, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        end
        clear_inputs();
        push("b2b_saturated", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0); tick();
        nChecks++;
        if (stall_count !== 4'hF) begin
            nBad++;
            $display("FAIL cnt_saturate: got %0d required 15", stall_count);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_deferred_flush();
        test_watchdog();
        test_back_to_back();
        if (expQ.size() != 0) begin
            nChecks++;
            nBad++;
            $display("FAIL sb_leftover: got %0d unconsumed entries required 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
